// File: rtl/sevenseg_pkg.sv
// Shared 7-segment pattern constants, decode result type and helpers for the scan decoder.
// Active-low patterns are {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] DIGIT_ERR = 4'hF;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       illegal;
    } seg_dec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_PUBLISH
    } conv_state_e;

    function automatic seg_dec_t seg_to_bcd(input logic [6:0] seg);
        seg_dec_t r;
        r = '{digit: 4'd0, blank: 1'b0, illegal: 1'b0};
        case (seg)
            SEG_0:     r.digit = 4'd0;
            SEG_1:     r.digit = 4'd1;
            SEG_2:     r.digit = 4'd2;
            SEG_3:     r.digit = 4'd3;
            SEG_4:     r.digit = 4'd4;
            SEG_5:     r.digit = 4'd5;
            SEG_6:     r.digit = 4'd6;
            SEG_7:     r.digit = 4'd7;
            SEG_8:     r.digit = 4'd8;
            SEG_9:     r.digit = 4'd9;
            SEG_BLANK: r.blank = 1'b1;
            default: begin
                r.digit   = DIGIT_ERR;
                r.illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

    // Error digits contribute zero to the binary value; blanks already decode to 0.
    function automatic logic [3:0] digit_value(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of one active-low segment pattern into {digit, blank, illegal}.
module seg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output seg_dec_t   dec_c
);

    assign dec_c = seg_to_bcd(seg_i);

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display: sync, debounce, decode and publish whole frames.
// Optional macro SEVENSEG_BINARY_OUT_EN adds bin_out with a sequential BCD-to-binary converter.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    frame_valid,
    output logic                    frame_err,
`ifdef SEVENSEG_BINARY_OUT_EN
    output logic [4*NUM_DIGITS-1:0] bin_out,
`endif
    output logic                    stale
);

    localparam int unsigned SMP_W = NUM_DIGITS + 7;
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [SMP_W-1:0]      sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d, blank_stg_q, blank_stg_d, blank_q, blank_d;
    logic [BCD_W-1:0]      bcd_stg_q, bcd_stg_d, bcd_q, bcd_d;
    logic                  err_stg_q, err_stg_d, err_q, err_d;
    logic                  fv_q, fv_d, stale_q, stale_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [NUM_DIGITS-1:0] sel_n_c;
    logic [6:0]            seg_c;
    seg_dec_t              dec_c;
    logic [IDX_W-1:0]      slot_c;
    logic                  capture_c, frame_start_c;

    assign sel_n_c = sync2_q[SMP_W-1:7];
    assign seg_c   = sync2_q[6:0];

    seg_pattern_decode u_decode (
        .seg_i (seg_c),
        .dec_c (dec_c)
    );

    // Slot index of the single active strobe (only meaningful when one-cold).
    always_comb begin
        slot_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_n_c[i]) slot_c = IDX_W'(i);
        end
    end

    // Capture fires only on the cycle the count first reaches its limit.
    always_comb begin
        cnt_d = '0;
        if ((sync2_q == prev_q) && $onehot(~sel_n_c)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        capture_c = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end

    // Opening a new frame clears the mask first, so a capture in that cycle starts the next frame.
    always_comb begin
        mask_d      = frame_start_c ? '0 : mask_q;
        err_stg_d   = frame_start_c ? 1'b0 : err_stg_q;
        bcd_stg_d   = bcd_stg_q;
        blank_stg_d = blank_stg_q;
        if (capture_c && !mask_d[slot_c]) begin
            mask_d[slot_c]            = 1'b1;
            bcd_stg_d[4*slot_c +: 4]  = dec_c.digit;
            blank_stg_d[slot_c]       = dec_c.blank;
            err_stg_d                 = err_stg_d | dec_c.illegal;
        end
    end

`ifdef SEVENSEG_BINARY_OUT_EN
    conv_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BCD_W-1:0]      acc_q, acc_d, bin_q, bin_d;
    logic [BCD_W-1:0]      snap_bcd_q, snap_bcd_d;
    logic [NUM_DIGITS-1:0] snap_blank_q, snap_blank_d;
    logic                  snap_err_q, snap_err_d;

    // A full mask waits in IDLE until any running conversion has published.
    assign frame_start_c = (state_q == ST_IDLE) && (&mask_q);

    // Horner conversion, MSD folded in on frame start, one further digit per cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        bin_d        = bin_q;
        snap_bcd_d   = snap_bcd_q;
        snap_blank_d = snap_blank_q;
        snap_err_d   = snap_err_q;
        bcd_d        = bcd_q;
        blank_d      = blank_q;
        err_d        = err_q;
        fv_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start_c) begin
                    snap_bcd_d   = bcd_stg_q;
                    snap_blank_d = blank_stg_q;
                    snap_err_d   = err_stg_q;
                    acc_d        = BCD_W'(digit_value(bcd_stg_q[BCD_W-1 -: 4]));
                    idx_d        = IDX_W'((NUM_DIGITS > 1) ? NUM_DIGITS - 2 : 0);
                    state_d      = (NUM_DIGITS > 1) ? ST_CONVERT : ST_PUBLISH;
                end
            end
            ST_CONVERT: begin
                acc_d = acc_q * BCD_W'(10) + BCD_W'(digit_value(snap_bcd_q[4*idx_q +: 4]));
                if (idx_q == '0) state_d = ST_PUBLISH;
                else             idx_d   = idx_q - IDX_W'(1);
            end
            ST_PUBLISH: begin
                bcd_d   = snap_bcd_q;
                blank_d = snap_blank_q;
                err_d   = snap_err_q;
                bin_d   = acc_q;
                fv_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            bin_q        <= '0;
            snap_bcd_q   <= '0;
            snap_blank_q <= '0;
            snap_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            bin_q        <= bin_d;
            snap_bcd_q   <= snap_bcd_d;
            snap_blank_q <= snap_blank_d;
            snap_err_q   <= snap_err_d;
        end
    end

    assign bin_out = bin_q;
`else
    assign frame_start_c = &mask_q;

    always_comb begin
        bcd_d   = frame_start_c ? bcd_stg_q   : bcd_q;
        blank_d = frame_start_c ? blank_stg_q : blank_q;
        err_d   = frame_start_c ? err_stg_q   : err_q;
        fv_d    = frame_start_c;
    end
`endif

    // Staleness timer restarts on every published frame and saturates.
    always_comb begin
        tmo_d   = tmo_q;
        stale_d = stale_q;
        if (fv_d) begin
            tmo_d   = '0;
            stale_d = 1'b0;
        end else begin
            if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
            stale_d = (tmo_d == TMO_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            bcd_stg_q   <= '0;
            blank_stg_q <= '0;
            err_stg_q   <= 1'b0;
            bcd_q       <= '0;
            blank_q     <= '1;
            err_q       <= 1'b0;
            fv_q        <= 1'b0;
            tmo_q       <= '0;
            stale_q     <= 1'b0;
        end else begin
            sync1_q     <= {dig_sel_n, seg_in};
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            bcd_stg_q   <= bcd_stg_d;
            blank_stg_q <= blank_stg_d;
            err_stg_q   <= err_stg_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            err_q       <= err_d;
            fv_q        <= fv_d;
            tmo_q       <= tmo_d;
            stale_q     <= stale_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign blank_out   = blank_q;
    assign frame_valid = fv_q;
    assign frame_err   = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: directed scans plus random segment streams
// against a slot/duration-level frame model. Honours SEVENSEG_BINARY_OUT_EN for bin_out.
module tb_sevenseg_scan_decoder;

    localparam int ND  = 4;
    localparam int ST  = 16;
    localparam int TMO = 400;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] dig_sel_n;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] blank_out;
    logic          frame_valid, frame_err, stale;
`ifdef SEVENSEG_BINARY_OUT_EN
    logic [4*ND-1:0] bin_out;
`endif

    sevenseg_scan_decoder #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (ST),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .dig_sel_n   (dig_sel_n),
        .bcd_out     (bcd_out),
        .blank_out   (blank_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
`ifdef SEVENSEG_BINARY_OUT_EN
        .bin_out     (bin_out),
`endif
        .stale       (stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        err;
        int unsigned bin;
    } frame_t;

    frame_t     exp_q[$];
    frame_t     mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         frames_seen = 0;
    int         n_pushed = 0;
    int         cyc = 0;
    int         last_fv_cyc = 0;
    logic       fv_prev = 1'b0;
    logic [6:0] pat [10];
    bit         mgot [ND];
    int         mdig [ND];
    bit         mblank [ND];
    bit         merr;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        assert (got_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic void decode(input logic [6:0] p, output int d, output bit bl, output bit ill);
        d = 0; bl = 1'b0; ill = 1'b1;
        if (p == 7'h7F) begin
            bl = 1'b1; ill = 1'b0;
        end else begin
            for (int k = 0; k < 10; k++) if (pat[k] == p) begin d = k; ill = 1'b0; end
        end
        if (ill) d = 15;
    endfunction

    // A held slot of dur samples is accepted iff dur >= ST and the slot is still open this frame.
    function automatic void model_slot(input int s, input logic [6:0] p, input int dur);
        int d; bit bl, ill; frame_t f; int unsigned w;
        if (dur < ST || mgot[s]) return;
        decode(p, d, bl, ill);
        mgot[s] = 1'b1; mdig[s] = d; mblank[s] = bl; merr = merr | ill;
        for (int i = 0; i < ND; i++) if (!mgot[i]) return;
        f.bcd = '0; f.blank = '0; f.err = merr; f.bin = 0; w = 1;
        for (int i = 0; i < ND; i++) begin
            f.bcd[4*i +: 4] = 4'(mdig[i]);
            f.blank[i]      = mblank[i];
            f.bin          += ((mdig[i] <= 9) ? mdig[i] : 0) * w;
            w              *= 10;
            mgot[i]         = 1'b0;
        end
        merr = 1'b0;
        exp_q.push_back(f);
        n_pushed++;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input int s, input logic [6:0] p, input int dur, input int gap);
        model_slot(s, p, dur);
        dig_sel_n = ~(ND'(1) << s);
        seg_in    = p;
        tick(dur);
        if (gap > 0) begin
            dig_sel_n = '1;
            seg_in    = 7'h7F;
            tick(gap);
        end
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin tick(1); k++; end
        tick(2);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_bcd"},   32'(bcd_out),     32'h0);
        check({pfx, "_blank"}, 32'(blank_out),   32'hF);
        check({pfx, "_fv"},    32'(frame_valid), 32'h0);
        check({pfx, "_err"},   32'(frame_err),   32'h0);
        check({pfx, "_stale"}, 32'(stale),       32'h0);
`ifdef SEVENSEG_BINARY_OUT_EN
        check({pfx, "_bin"},   32'(bin_out),     32'h0);
`endif
    endtask

    // Frame monitor: every published frame must match the next modelled frame.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset_n === 1'b1 && frame_valid === 1'b1) begin
            frames_seen++;
            last_fv_cyc = cyc;
            n_checks++;
            assert (exp_q.size() > 0 && fv_prev !== 1'b1) else begin
                n_fail++;
                $error("FAIL unexpected_frame: pending %0d prev_fv %0b bcd %h", exp_q.size(), fv_prev, bcd_out);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("frame_bcd",   32'(bcd_out),   32'(mon_e.bcd));
                check("frame_blank", 32'(blank_out), 32'(mon_e.blank));
                check("frame_err",   32'(frame_err), 32'(mon_e.err));
                check("frame_stale", 32'(stale),     32'h0);
`ifdef SEVENSEG_BINARY_OUT_EN
                check("frame_bin",   32'(bin_out),   mon_e.bin);
`endif
            end
        end
        fv_prev = frame_valid;
    end

    initial begin
        int f0, s, r, dur;
        logic [6:0] p;
        int d; bit bl, ill;

        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
        for (int i = 0; i < ND; i++) begin mgot[i] = 1'b0; mdig[i] = 0; mblank[i] = 1'b0; end
        merr      = 1'b0;
        reset_n   = 1'b0;
        seg_in    = 7'h7F;
        dig_sel_n = '1;
        tick(3);
        check_reset_vals("reset");
        reset_n = 1'b1;
        tick(2);

        // Basic scan 1,2,3,4 LSD first
        drive(0, pat[1], 20, 1); drive(1, pat[2], 20, 1);
        drive(2, pat[3], 20, 1); drive(3, pat[4], 20, 1);
        wait_drain("drain_basic");
        check("basic_bcd", 32'(bcd_out), 32'h4321);
        check("basic_blank", 32'(blank_out), 32'h0);
        check("basic_err", 32'(frame_err), 32'h0);
        check("basic_count", 32'(frames_seen), 32'd1);

        // Slot 2 too short twice, then long enough
        for (int k = 0; k < 2; k++) begin
            drive(0, pat[5], 20, 1); drive(1, pat[6], 20, 1);
            drive(2, pat[7], 10, 1); drive(3, pat[8], 20, 1);
        end
        tick(10);
        check("short_no_frame", 32'(frames_seen), 32'd1);
        drive(2, pat[7], 20, 1);
        wait_drain("drain_short");
        check("short_bcd", 32'(bcd_out), 32'h8765);

        // Illegal pattern in slot 1, then a clean frame
        drive(0, pat[0], 20, 1); drive(1, 7'b1010101, 20, 1);
        drive(2, pat[9], 20, 1); drive(3, pat[3], 20, 1);
        wait_drain("drain_illegal");
        check("illegal_bcd", 32'(bcd_out), 32'h39F0);
        check("illegal_err", 32'(frame_err), 32'h1);
        drive(0, pat[2], 20, 1); drive(1, pat[4], 20, 1);
        drive(2, pat[6], 20, 1); drive(3, pat[8], 20, 1);
        wait_drain("drain_clean");
        check("clean_err", 32'(frame_err), 32'h0);
        check("clean_bcd", 32'(bcd_out), 32'h8642);

        // Blank slot 3; glitch splits slot 2 into two short runs
        f0 = frames_seen;
        drive(0, pat[1], 20, 1); drive(1, pat[2], 20, 1);
        drive(2, pat[5], 10, 0); drive(2, 7'b0101010, 1, 0); drive(2, pat[5], 10, 1);
        drive(3, 7'h7F, 20, 1);
        tick(5);
        check("glitch_no_frame", 32'(frames_seen), 32'(f0));
        drive(2, pat[5], 20, 1);
        wait_drain("drain_blank");
        check("blank_flags", 32'(blank_out), 32'h8);
        check("blank_bcd", 32'(bcd_out), 32'h0521);

        // Duration boundary: 15 samples rejected, 16 accepted; digits 9,8,7,6
        f0 = frames_seen;
        for (int i = 0; i < ND; i++) drive(i, pat[9-i], 15, 1);
        tick(5);
        check("boundary15_no_frame", 32'(frames_seen), 32'(f0));
        for (int i = 0; i < ND; i++) drive(i, pat[9-i], 16, 1);
        wait_drain("drain_boundary16");
        check("boundary16_bcd", 32'(bcd_out), 32'h6789);
`ifdef SEVENSEG_BINARY_OUT_EN
        check("boundary16_bin", 32'(bin_out), 32'd6789);
`endif

        // Idle until timeout: stale asserts, outputs hold
        while (cyc - last_fv_cyc < TMO - 10) tick(1);
        check("stale_early", 32'(stale), 32'h0);
        tick(20);
        check("stale_late", 32'(stale), 32'h1);
        check("stale_hold_bcd", 32'(bcd_out), 32'h6789);
        check("stale_hold_fv", 32'(frame_valid), 32'h0);

        // Random segment stream (mixed durations, repeats, blanks, illegal patterns)
        for (int n = 0; n < 120; n++) begin
            s = $urandom_range(ND-1, 0);
            r = $urandom_range(9, 0);
            if (r < 7) p = pat[$urandom_range(9, 0)];
            else if (r < 8) p = 7'h7F;
            else begin
                p = 7'($urandom);
                decode(p, d, bl, ill);
                if (!ill) p = 7'b1010101;
            end
            dur = $urandom_range(24, 8);
            drive(s, p, dur, $urandom_range(2, 1));
        end
        wait_drain("drain_random");
        check("random_count", 32'(frames_seen), 32'(n_pushed));

        // Reset mid-frame discards partial captures
        drive(0, pat[3], 20, 1); drive(1, pat[4], 20, 1);
        reset_n = 1'b0;
        tick(2);
        check_reset_vals("midreset");
        for (int i = 0; i < ND; i++) mgot[i] = 1'b0;
        merr    = 1'b0;
        reset_n = 1'b1;
        tick(2);
        f0 = frames_seen;
        drive(2, pat[0], 20, 1); drive(3, pat[1], 20, 1);
        tick(5);
        check("midreset_no_frame", 32'(frames_seen), 32'(f0));
        drive(0, pat[7], 20, 1); drive(1, pat[0], 20, 1);
        wait_drain("drain_midreset");
        check("midreset_bcd", 32'(bcd_out), 32'h1007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
